fp_add_pipe: RTL and testbench
==============================

// Module: fp_add_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. Accepts one operand
//  pair per cycle under valid/ready handshake, result after 3 cycles. Full sign handling, RNE
//  rounding, special values, status flags. Sits between operand source and FP result sink.
// PARAMETERS
//  EXP_W  8   exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W  23  stored mantissa width (hidden bit implicit); word width W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    adder accepts pair this cycle
//  a          in   W    operand A {sign, exp, man}
//  b          in   W    operand B
//  op         in   1    0 = A+B, 1 = A-B (B sign inverted at input)
//  out_valid  out  1    result valid
//  out_ready  in   1    sink accepts result
//  sum        out  W    result
//  flags      out  4    {invalid, overflow, underflow, inexact} for this result
// BEHAVIOUR
//  Reset: all stage valids, out_valid, sum, flags = 0; in-flight ops discarded, no output.
//  Handshake: adv = !out_valid | out_ready; in_ready = adv. Transfer on in_valid & in_ready;
//   result consumed on out_valid & out_ready. All stages shift together when adv=1, hold when 0.
//   sum/flags stable while out_valid & !out_ready. Bubbles propagate as stage valid=0.
//  Throughput 1/cycle; latency exactly 3 cycles from accept to out_valid when never stalled.
//  S1 align: effective signs (b sign ^ op); swap so |X| >= |Y| (exp, then mantissa);
//   prepend hidden 1; shift Y right by exp diff into MAN_W+4 bits (guard, round, sticky);
//   diff >= MAN_W+3 -> Y becomes sticky only. Classify zero/inf/NaN.
//  S2 add: same signs -> add, else X-Y; result sign = sign of X. Carry out kept (1 extra bit).
//  S3 normalise/round/pack: carry -> shift right 1, exp+1 (sticky OR-ed); else leading-zero
//   count, shift left, exp-lzc. Round to nearest, ties to even; mantissa carry from rounding
//   re-normalises (exp+1). inexact = any of G/R/S nonzero before rounding.
//  Denormals: exp==0 inputs treated as signed zero (flush); results with exp <= 0 -> signed
//   zero, underflow=1, inexact=1.
//  Overflow: exp after rounding >= all-ones -> inf with result sign, overflow=1, inexact=1.
//  Exact cancellation (X-Y=0) -> +0. Zero+zero: -0 only if both effective signs negative.
//  x+0 -> x exactly (flags 0). inf+finite -> that inf. inf+inf same sign -> inf.
//  NaN input, or inf+inf opposite effective signs -> canonical NaN {0, all-ones, 1, 0...},
//   invalid=1 for inf-inf or any NaN with mantissa MSB=0 (signalling); else invalid=0.
//  Special-case results bypass arithmetic but keep the same 3-cycle latency and ordering.
//  Exponent arithmetic done in EXP_W+2 signed bits; no wrap-around permitted.
// TESTING (defaults EXP_W=8, MAN_W=23; op=0 unless stated)
//  1. 0x3F800000+0x3F800000 -> 0x40000000, flags 0, out_valid exactly 3 cycles after accept.
//  2. 0x3FC00000 op=1 0x3FC00000 -> 0x00000000; 0x40400000+0xC0000000 -> 0x3F800000.
//  3. 0x3F800000+0x33800000 (tie) -> 0x3F800000 inexact; +0x33800001 -> 0x3F800001 inexact.
//  4. 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000 overflow+inexact; 0x7F800000+0xFF800000 -> 0x7FC00000
//     invalid; 0x00400000+0x3F800000 -> 0x3F800000 (denormal flushed), flags 0.
//  5. Stream 10 back-to-back pairs, hold out_ready=0 cycles 4-7: in_ready=0 during hold, no
//     result lost/duplicated, results in order, sum stable while stalled.
//  6. Assert rst mid-stream with 3 ops in flight: outputs 0 immediately, no stale result after
//     release; next accepted op returns correct result after 3 cycles.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined floating-point adder/subtractor with RNE rounding, specials and flags
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic [3:0]   flags
);
  localparam int MW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int LW = $clog2(MW + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);
  logic sa, sb, a_ge, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nan_in, inf_inf, spec;
  logic [EXP_W-1:0] ea, eb, ex, ey, diff;
  logic [MAN_W-1:0] ma, mb;
  logic [MW-1:0] mx_al, my_full, my_mask, my_al;
  logic [W-1:0] spec_res;
  logic [3:0] spec_flg;
  logic v1, p1, s1, sub1;
  logic [W-1:0] r1;
  logic [3:0] f1;
  logic [EXP_W-1:0] e1;
  logic [MW-1:0] mx1, my1;
  logic v2, p2, s2;
  logic [W-1:0] r2;
  logic [3:0] f2;
  logic [EXP_W-1:0] e2;
  logic [MW:0] m2;
  logic carry, rnd, inx;
  logic [LW-1:0] lz;
  logic [MW-1:0] norm;
  logic signed [EW-1:0] ee, ef;
  logic [MAN_W+1:0] man_r;
  logic [MAN_W-1:0] mf;
  logic [W-1:0] res;
  logic [3:0] flg;
  assign in_ready = !out_valid | out_ready;
  // align: effective signs, magnitude swap, shift smaller operand with sticky, classify specials
  always_comb begin
    sa = a[W-1];
    sb = b[W-1] ^ op;
    ea = a[W-2:MAN_W];
    eb = b[W-2:MAN_W];
    ma = a[MAN_W-1:0];
    mb = b[MAN_W-1:0];
    a_zero = ea == '0;
    b_zero = eb == '0;
    a_inf = &ea && ma == '0;
    b_inf = &eb && mb == '0;
    a_nan = &ea && ma != '0;
    b_nan = &eb && mb != '0;
    nan_in = a_nan | b_nan;
    inf_inf = a_inf & b_inf & (sa != sb);
    spec = nan_in | a_inf | b_inf | a_zero | b_zero;
    spec_res = (nan_in | inf_inf) ? QNAN : a_inf ? a : b_inf ? {sb, b[W-2:0]} :
               (a_zero & b_zero) ? {sa & sb, {(W-1){1'b0}}} : b_zero ? a : {sb, b[W-2:0]};
    spec_flg = {inf_inf | (a_nan & !ma[MAN_W-1]) | (b_nan & !mb[MAN_W-1]), 3'b000};
    a_ge = a[W-2:0] >= b[W-2:0];
    ex = a_ge ? ea : eb;
    ey = a_ge ? eb : ea;
    diff = ex - ey;
    mx_al = {1'b1, a_ge ? ma : mb, 3'b000};
    my_full = {1'b1, a_ge ? mb : ma, 3'b000};
    my_mask = (MW'(1) << diff) - MW'(1);
    my_al = int'(diff) >= MAN_W + 3 ? MW'(1) : (my_full >> diff) | MW'(|(my_full & my_mask));
  end
  // stage 1 register: aligned operands or bypassed special result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1, p1, s1, sub1, r1, f1, e1, mx1, my1} <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      p1 <= spec;
      r1 <= spec_res;
      f1 <= spec_flg;
      s1 <= a_ge ? sa : sb;
      sub1 <= sa != sb;
      e1 <= ex;
      mx1 <= mx_al;
      my1 <= my_al;
    end
  end
  // stage 2 register: magnitude add or subtract with one carry bit kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v2, p2, s2, r2, f2, e2, m2} <= '0;
    end else if (in_ready) begin
      v2 <= v1;
      p2 <= p1;
      r2 <= r1;
      f2 <= f1;
      s2 <= s1;
      e2 <= e1;
      m2 <= sub1 ? {1'b0, mx1} - {1'b0, my1} : {1'b0, mx1} + {1'b0, my1};
    end
  end
  // normalise, round to nearest even, detect overflow/underflow and pack
  always_comb begin
    lz = '0;
    for (int i = 0; i < MW; i++) if (m2[i]) lz = LW'(MW - 1 - i);
    carry = m2[MW];
    norm = carry ? {m2[MW:2], |m2[1:0]} : m2[MW-1:0] << lz;
    ee = carry ? {2'b00, e2} + EW'(1) : {2'b00, e2} - EW'(lz);
    rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
    inx = |norm[2:0];
    man_r = {1'b0, norm[MW-1:3]} + (MAN_W+2)'(rnd);
    mf = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
    ef = ee + EW'(man_r[MAN_W+1]);
    res = p2 ? r2 : m2 == '0 ? '0 : (ef[EW-1] || ef == '0) ? {s2, {(W-1){1'b0}}} :
          ef >= EMAX ? {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {s2, ef[EXP_W-1:0], mf};
    flg = p2 ? f2 : m2 == '0 ? 4'b0000 : (ef[EW-1] || ef == '0) ? 4'b0011 :
          ef >= EMAX ? 4'b0101 : {3'b000, inx};
  end
  // output register: held while the sink stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {out_valid, sum, flags} <= '0;
    end else if (in_ready) begin
      out_valid <= v2;
      sum <= res;
      flags <= flg;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: scoreboard bench for fp_add_pipe with directed vectors, stall and reset checks
module tb_fp_add_pipe;
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic op; logic [31:0] s; logic [3:0] f;} vec_t;
  typedef struct {logic [31:0] s; logic [3:0] f; int c; bit l; int id;} exp_t;
  localparam vec_t V [19] = '{
    '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000},
    '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 4'b0000},
    '{32'h40400000, 32'hC0000000, 1'b0, 32'h3F800000, 4'b0000},
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},
    '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},
    '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000},
    '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},
    '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},
    '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 4'b0000},
    '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000},
    '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000},
    '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000},
    '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011},
    '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000},
    '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000},
    '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000},
    '{32'h4B7FFFFF, 32'h3F000000, 1'b0, 32'h4B800000, 4'b0001}
  };
  logic clk = 0, rst = 1, in_valid = 0, op = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [31:0] a = 0, b = 0, sum;
  logic [3:0] flags;
  int cyc = 0, pass_n = 0, tot_n = 0, st0 = 0, st1 = 0;
  exp_t q[$];
  exp_t e;
  bit held = 0;
  logic [31:0] hs;
  logic [3:0] hf;
  fp_add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .flags(flags)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tot_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask
  task automatic send(input int id, input bit lat);
    int n = 0;
    @(negedge clk);
    in_valid = 1; a = V[id].a; b = V[id].b; op = V[id].op;
    #1;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (in_ready) q.push_back(exp_t'{V[id].s, V[id].f, cyc, lat, id});
    else chk($sformatf("accept_timeout[%0d]", id), 32'(in_ready), 1);
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 0;
    repeat (n - 1) @(negedge clk);
  endtask
  task automatic drain();
    for (int n = 0; n < 60 && q.size() != 0; n++) @(negedge clk);
    chk("drain_pending", 32'(q.size()), 0);
  endtask
  initial forever begin
    @(negedge clk);
    out_ready = !(cyc >= st0 && cyc < st1);
  end
  initial forever begin
    @(negedge clk);
    #2;
    if (held) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_sum", sum, hs);
      chk("stall_flags", 32'(flags), 32'(hf));
    end
    held = out_valid && !out_ready;
    hs = sum;
    hf = flags;
    if (held) chk("in_ready_stall", 32'(in_ready), 0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_out: got sum %h with no pending op", sum);
      end else begin
        e = q.pop_front();
        chk($sformatf("sum[%0d]", e.id), sum, e.s);
        chk($sformatf("flags[%0d]", e.id), 32'(flags), 32'(e.f));
        if (e.l) chk($sformatf("latency[%0d]", e.id), 32'(cyc - e.c), 3);
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 0;
    for (int i = 0; i < 19; i++) begin send(i, 1); idle(4); end
    drain();
    st0 = cyc + 5;
    st1 = cyc + 9;
    for (int i = 0; i < 10; i++) send(i, 0);
    idle(4);
    drain();
    for (int i = 10; i < 13; i++) send(i, 1);
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    q.delete();
    rst = 1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_flags", 32'(flags), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    send(13, 1);
    idle(6);
    drain();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
